// File: rtl/output_serializer.sv
// Two-slot bundle buffer that unpacks P-lane bundles into a stream of single
// samples, lane 0 first, with ready/valid handshakes on both sides.
module output_serializer #(
    parameter int WIDTH = 8,
    parameter int P     = 4,
    parameter int LOGP  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [P*WIDTH-1:0]      s_data_in_y,
    input  logic                    s_valid_y,
    output logic                    s_ready_y,
    output logic signed [WIDTH-1:0] m_data_out_y,
    output logic                    m_valid_y,
    input  logic                    m_ready_y,
    output logic                    m_last_y
);

    localparam logic [LOGP-1:0] LAST_LANE = LOGP'(P - 1);

    logic [1:0]         count_q, count_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [LOGP-1:0]    lane_q, lane_d;
    logic [P*WIDTH-1:0] slot0_q, slot0_d;
    logic [P*WIDTH-1:0] slot1_q, slot1_d;
    logic [P*WIDTH-1:0] rd_slot;
    logic               accept;
    logic               xfer;
    logic               final_xfer;

    // Handshake status comes from registered occupancy only, so there is no
    // combinational path between the two sides.
    assign s_ready_y = (count_q < 2'd2);
    assign m_valid_y = (count_q != 2'd0);
    assign m_last_y  = m_valid_y && (lane_q == LAST_LANE);

    always_comb begin
        accept     = s_valid_y && s_ready_y;
        xfer       = m_valid_y && m_ready_y;
        final_xfer = xfer && (lane_q == LAST_LANE);

        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lane_d   = lane_q;
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;

        if (accept) begin
            if (wr_ptr_q) begin
                slot1_d = s_data_in_y;
            end else begin
                slot0_d = s_data_in_y;
            end
            wr_ptr_d = ~wr_ptr_q;
        end

        if (final_xfer) begin
            lane_d   = '0;
            rd_ptr_d = ~rd_ptr_q;
        end else if (xfer) begin
            lane_d = lane_q + 1'b1;
        end

        case ({accept, final_xfer})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rd_slot = rd_ptr_q ? slot1_q : slot0_q;
        if (m_valid_y) begin
            m_data_out_y = rd_slot[int'(lane_q)*WIDTH +: WIDTH];
        end else begin
            m_data_out_y = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            lane_q   <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lane_q   <= lane_d;
        end
    end

    // Slot contents are only ever read while count marks them occupied,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

endmodule

// File: tb/tb_output_serializer.sv
// Self-checking bench for output_serializer: directed corner cases with literal
// expectations plus a long randomized run scored against a sample-queue model.
module tb_output_serializer;

    localparam int WIDTH = 8;
    localparam int P     = 4;
    localparam int LOGP  = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [P*WIDTH-1:0]      s_data_in_y = '0;
    logic                    s_valid_y = 1'b0;
    logic                    m_ready_y = 1'b0;
    logic                    s_ready_y;
    logic signed [WIDTH-1:0] m_data_out_y;
    logic                    m_valid_y;
    logic                    m_last_y;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a flat queue of pending samples in emission order.
    logic [WIDTH-1:0] exp_q[$];
    int               popped = 0;
    int               accepted = 0;
    bit               mdl_acc;
    bit               mdl_xfer;

    output_serializer #(.WIDTH(WIDTH), .P(P), .LOGP(LOGP)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_y  (s_data_in_y),
        .s_valid_y    (s_valid_y),
        .s_ready_y    (s_ready_y),
        .m_data_out_y (m_data_out_y),
        .m_valid_y    (m_valid_y),
        .m_ready_y    (m_ready_y),
        .m_last_y     (m_last_y)
    );

    always #5 clk = ~clk;

    function automatic int model_valid();
        return (exp_q.size() > 0) ? 1 : 0;
    endfunction

    function automatic int model_data();
        return (exp_q.size() > 0) ? int'($signed(exp_q[0])) : 0;
    endfunction

    function automatic int model_last();
        return (exp_q.size() > 0 && (popped % P) == P - 1) ? 1 : 0;
    endfunction

    // Bundles held = pending samples rounded up to whole bundles.
    function automatic int model_sready();
        return (((exp_q.size() + P - 1) / P) < 2) ? 1 : 0;
    endfunction

    function automatic logic [P*WIDTH-1:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int required);
        n_checks++;
        if (actual == required) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: actual=%0d required=%0d at t=%0t", name, actual, required, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic ready, input logic [P*WIDTH-1:0] data);
        s_valid_y   = valid;
        m_ready_y   = ready;
        s_data_in_y = data;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            popped = 0;
        end else begin
            mdl_acc  = s_valid_y && (model_sready() == 1);
            mdl_xfer = m_ready_y && (exp_q.size() > 0);
            if (mdl_xfer) begin
                void'(exp_q.pop_front());
                popped++;
            end
            if (mdl_acc) begin
                for (int i = 0; i < P; i++) begin
                    exp_q.push_back(s_data_in_y[i*WIDTH +: WIDTH]);
                end
                accepted++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("cmp_m_valid", int'(m_valid_y), model_valid());
            checkOutput("cmp_m_data", int'(m_data_out_y), model_data());
            checkOutput("cmp_m_last", int'(m_last_y), model_last());
            checkOutput("cmp_s_ready", int'(s_ready_y), model_sready());
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        int cyc;

        #2;
        checkOutput("rst_m_valid", int'(m_valid_y), 0);
        checkOutput("rst_m_data", int'(m_data_out_y), 0);
        checkOutput("rst_m_last", int'(m_last_y), 0);
        checkOutput("rst_s_ready", int'(s_ready_y), 1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        $display("[TB] single bundle with downstream always ready");
        applyStimulus(1'b1, 1'b1, pack4(5, -3, 127, -128));
        cycle();
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("b1_lane0", int'(m_data_out_y), 5);
        checkOutput("b1_last0", int'(m_last_y), 0);
        checkOutput("b1_valid0", int'(m_valid_y), 1);
        cycle();
        checkOutput("b1_lane1", int'(m_data_out_y), -3);
        checkOutput("b1_last1", int'(m_last_y), 0);
        cycle();
        checkOutput("b1_lane2", int'(m_data_out_y), 127);
        checkOutput("b1_last2", int'(m_last_y), 0);
        cycle();
        checkOutput("b1_lane3", int'(m_data_out_y), -128);
        checkOutput("b1_last3", int'(m_last_y), 1);
        cycle();
        checkOutput("b1_empty", int'(m_valid_y), 0);

        $display("[TB] back-to-back bundles with downstream stalled");
        applyStimulus(1'b1, 1'b0, pack4(1, 2, 3, 4));
        cycle();
        checkOutput("full_sready1", int'(s_ready_y), 1);
        checkOutput("full_hold1", int'(m_data_out_y), 1);
        applyStimulus(1'b1, 1'b0, pack4(11, 12, 13, 14));
        cycle();
        checkOutput("full_sready2", int'(s_ready_y), 0);
        checkOutput("full_hold2", int'(m_data_out_y), 1);
        applyStimulus(1'b1, 1'b0, pack4(21, 22, 23, 24));
        cycle();
        checkOutput("full_sready3", int'(s_ready_y), 0);
        checkOutput("full_hold3", int'(m_data_out_y), 1);
        checkOutput("full_hold_last", int'(m_last_y), 0);
        applyStimulus(1'b0, 1'b1, '0);
        repeat (8) cycle();
        checkOutput("full_third_dropped", int'(m_valid_y), 0);

        $display("[TB] final-lane transfer and accept on the same edge");
        applyStimulus(1'b1, 1'b1, pack4(31, 32, 33, 34));
        cycle();
        applyStimulus(1'b0, 1'b1, '0);
        repeat (3) cycle();
        checkOutput("swap_lane3", int'(m_data_out_y), 34);
        checkOutput("swap_last", int'(m_last_y), 1);
        applyStimulus(1'b1, 1'b1, pack4(41, 42, 43, 44));
        cycle();
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("swap_valid", int'(m_valid_y), 1);
        checkOutput("swap_lane0", int'(m_data_out_y), 41);
        checkOutput("swap_sready", int'(s_ready_y), 1);
        repeat (6) cycle();

        $display("[TB] final-lane transfer while both slots are full");
        applyStimulus(1'b1, 1'b0, pack4(51, 52, 53, 54));
        cycle();
        applyStimulus(1'b1, 1'b0, pack4(61, 62, 63, 64));
        cycle();
        applyStimulus(1'b0, 1'b1, '0);
        repeat (3) cycle();
        checkOutput("nobypass_lane3", int'(m_data_out_y), 54);
        checkOutput("nobypass_sready", int'(s_ready_y), 0);
        applyStimulus(1'b1, 1'b1, pack4(71, 72, 73, 74));
        #1;
        checkOutput("nobypass_sready_comb", int'(s_ready_y), 0);
        cycle();
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("nobypass_sready_next", int'(s_ready_y), 1);
        checkOutput("nobypass_next_lane0", int'(m_data_out_y), 61);
        repeat (4) cycle();
        checkOutput("nobypass_drained", int'(m_valid_y), 0);

        $display("[TB] reset asserted mid-bundle");
        applyStimulus(1'b1, 1'b1, pack4(81, 82, 83, 84));
        cycle();
        applyStimulus(1'b0, 1'b1, '0);
        cycle();
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_valid", int'(m_valid_y), 0);
        checkOutput("midrst_data", int'(m_data_out_y), 0);
        checkOutput("midrst_last", int'(m_last_y), 0);
        checkOutput("midrst_sready", int'(s_ready_y), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) cycle();
        checkOutput("midrst_no_stale", int'(m_valid_y), 0);
        applyStimulus(1'b1, 1'b1, pack4(91, 92, 93, 94));
        cycle();
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("midrst_new_lane0", int'(m_data_out_y), 91);
        repeat (6) cycle();

        $display("[TB] randomized traffic");
        start = accepted;
        cyc = 0;
        while (accepted - start < 1000 && cyc < 40000) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          {$urandom(), $urandom()} >> 32);
            cycle();
            cyc++;
        end
        checkOutput("rand_bundle_count", accepted - start, 1000);
        applyStimulus(1'b0, 1'b1, '0);
        repeat (12) cycle();
        checkOutput("rand_drained", int'(m_valid_y), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
